// File: rtl/obj_pkg.sv
// Object table geometry and shared types for the object renderer and motion stage.
package obj_pkg;
    localparam int unsigned NUM_OBJ   = 4;
    localparam int unsigned OBJ_VEL_W = 8;
    localparam int unsigned POS_W     = 12;

    // Element 0 is object 0.
    localparam logic [NUM_OBJ-1:0][POS_W-1:0] ObjSizeX = {12'd24, 12'd8, 12'd32, 12'd16};
    localparam logic [NUM_OBJ-1:0][POS_W-1:0] ObjSizeY = {12'd24, 12'd32, 12'd8, 12'd16};

    localparam int unsigned WALL_LEFT   = 0;
    localparam int unsigned WALL_RIGHT  = 1;
    localparam int unsigned WALL_TOP    = 2;
    localparam int unsigned WALL_BOTTOM = 3;

    typedef logic signed [OBJ_VEL_W-1:0] obj_vel_t;

    typedef struct packed {
        logic             en;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        obj_vel_t         vx;
        obj_vel_t         vy;
    } obj_state_t;
endpackage

// File: rtl/vga_hd_pkg.sv
// 1280x720 active-video geometry shared by the renderer and the motion stage.
package vga_hd_pkg;
    localparam int unsigned ActivePels  = 1280;
    localparam int unsigned ActiveLines = 720;
endpackage

// File: rtl/obj_axis_step.sv
// Single-axis position step with bounce off [lo, hi]; purely combinational.
module obj_axis_step #(
    parameter int unsigned VEL_W = 8
) (
    input  logic [11:0]             pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic signed [13:0]      lo_i,
    input  logic signed [13:0]      hi_i,
    output logic [11:0]             pos_o,
    output logic signed [VEL_W-1:0] vel_o,
    output logic                    hit_lo_o,
    output logic                    hit_hi_o
);
    localparam logic signed [VEL_W-1:0] VMIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};

    logic signed [13:0]      nx;
    logic signed [VEL_W-1:0] abs_v;

    always_comb begin
        nx       = $signed({2'b00, pos_i}) + 14'(vel_i);
        // |VMIN| does not fit, so it saturates to VMAX
        abs_v    = (vel_i == VMIN) ? VMAX : (vel_i[VEL_W-1] ? -vel_i : vel_i);
        pos_o    = 12'(nx);
        vel_o    = vel_i;
        hit_lo_o = 1'b0;
        hit_hi_o = 1'b0;
        if (hi_i < lo_i) begin
            pos_o = 12'(lo_i);
        end else if (nx < lo_i) begin
            pos_o    = 12'(lo_i);
            vel_o    = abs_v;
            hit_lo_o = 1'b1;
        end else if (nx > hi_i) begin
            pos_o    = 12'(hi_i);
            vel_o    = -abs_v;
            hit_hi_o = 1'b1;
        end
    end
endmodule

// File: rtl/obj_motion_engine.sv
// Per-frame object motion: steps every object sequentially in shadow state,
// then commits all positions to the renderer-facing outputs in one cycle.
module obj_motion_engine
    import obj_pkg::*;
    import vga_hd_pkg::*;
#(
    parameter int unsigned NUM_OBJ = obj_pkg::NUM_OBJ,
    parameter int unsigned VEL_W   = 8
) (
    input  logic                         vid_clk,
    input  logic                         vid_reset_n,
    input  logic                         frame_tick,
    input  logic [3:0][7:0]              frame_widths,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_OBJ)-1:0]   cfg_idx,
    input  logic                         cfg_en,
    input  logic [11:0]                  cfg_x,
    input  logic [11:0]                  cfg_y,
    input  logic signed [VEL_W-1:0]      cfg_vx,
    input  logic signed [VEL_W-1:0]      cfg_vy,
    output logic [NUM_OBJ-1:0][11:0]     obj_x,
    output logic [NUM_OBJ-1:0][11:0]     obj_y,
    output logic [NUM_OBJ-1:0]           obj_en,
    output logic [NUM_OBJ-1:0][3:0]      wall_hit,
    output logic                         busy,
    output logic                         overrun
);
    localparam int unsigned IDX_W = $clog2(NUM_OBJ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, overrun_q, overrun_d;

    logic [NUM_OBJ-1:0][11:0]      x_q, y_q;
    logic [NUM_OBJ-1:0][VEL_W-1:0] vx_q, vy_q;
    logic [NUM_OBJ-1:0]            en_q;
    logic [NUM_OBJ-1:0][3:0]       hit_acc_q;

    logic [NUM_OBJ-1:0][11:0] obj_x_q, obj_y_q;
    logic [NUM_OBJ-1:0]       obj_en_q;
    logic [NUM_OBJ-1:0][3:0]  wall_hit_q;

    logic signed [13:0]      x_lo, x_hi, y_lo, y_hi;
    logic [11:0]             nx_pos, ny_pos;
    logic signed [VEL_W-1:0] nx_vel, ny_vel;
    logic                    x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
    logic                    cfg_valid, step_en;

    assign cfg_valid = cfg_we && (32'(cfg_idx) < NUM_OBJ);
    // A same-index cfg write discards this cycle's step result
    assign step_en   = (state_q == S_UPDATE) && en_q[idx_q] && !(cfg_valid && (cfg_idx == idx_q));

    assign x_lo = 14'(frame_widths[WALL_LEFT]);
    assign x_hi = 14'(ActivePels) - 14'(frame_widths[WALL_RIGHT]) - 14'(ObjSizeX[idx_q]);
    assign y_lo = 14'(frame_widths[WALL_TOP]);
    assign y_hi = 14'(ActiveLines) - 14'(frame_widths[WALL_BOTTOM]) - 14'(ObjSizeY[idx_q]);

    obj_axis_step #(.VEL_W(VEL_W)) u_step_x (
        .pos_i(x_q[idx_q]), .vel_i($signed(vx_q[idx_q])), .lo_i(x_lo), .hi_i(x_hi),
        .pos_o(nx_pos), .vel_o(nx_vel), .hit_lo_o(x_hit_lo), .hit_hi_o(x_hit_hi)
    );

    obj_axis_step #(.VEL_W(VEL_W)) u_step_y (
        .pos_i(y_q[idx_q]), .vel_i($signed(vy_q[idx_q])), .lo_i(y_lo), .hi_i(y_hi),
        .pos_o(ny_pos), .vel_o(ny_vel), .hit_lo_o(y_hit_lo), .hit_hi_o(y_hit_hi)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_UPDATE;
                    idx_d   = '0;
                end
            end
            S_UPDATE: begin
                overrun_d = frame_tick;
                if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                overrun_d = frame_tick;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= (state_d != S_IDLE);
            overrun_q <= overrun_d;
        end
    end

    // Shadow object table: cfg writes take priority over the step result
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            x_q  <= '0;
            y_q  <= '0;
            vx_q <= '0;
            vy_q <= '0;
            en_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                if (cfg_valid && (32'(cfg_idx) == i)) begin
                    x_q[i]  <= cfg_x;
                    y_q[i]  <= cfg_y;
                    vx_q[i] <= cfg_vx;
                    vy_q[i] <= cfg_vy;
                    en_q[i] <= cfg_en;
                end else if (step_en && (32'(idx_q) == i)) begin
                    x_q[i]  <= nx_pos;
                    y_q[i]  <= ny_pos;
                    vx_q[i] <= nx_vel;
                    vy_q[i] <= ny_vel;
                end
            end
        end
    end

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            hit_acc_q <= '0;
        end else if ((state_q == S_IDLE) && frame_tick) begin
            hit_acc_q <= '0;
        end else if (step_en) begin
            hit_acc_q[idx_q] <= {y_hit_hi, y_hit_lo, x_hit_hi, x_hit_lo};
        end
    end

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            obj_x_q    <= '0;
            obj_y_q    <= '0;
            obj_en_q   <= '0;
            wall_hit_q <= '0;
        end else if (state_q == S_COMMIT) begin
            obj_x_q    <= x_q;
            obj_y_q    <= y_q;
            obj_en_q   <= en_q;
            wall_hit_q <= hit_acc_q;
        end
    end

    assign obj_x    = obj_x_q;
    assign obj_y    = obj_y_q;
    assign obj_en   = obj_en_q;
    assign wall_hit = wall_hit_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_obj_motion_engine.sv
// Randomized scoreboard bench for obj_motion_engine against a frame-level reference model.
module tb_obj_motion_engine;
    localparam int N = 4;

    logic              vid_clk = 1'b0;
    logic              vid_reset_n;
    logic              frame_tick;
    logic [3:0][7:0]   frame_widths;
    logic              cfg_we;
    logic [1:0]        cfg_idx;
    logic              cfg_en;
    logic [11:0]       cfg_x, cfg_y;
    logic [7:0]        cfg_vx, cfg_vy;
    logic [N-1:0][11:0] obj_x, obj_y;
    logic [N-1:0]      obj_en;
    logic [N-1:0][3:0] wall_hit;
    logic              busy, overrun;

    obj_motion_engine #(.NUM_OBJ(N), .VEL_W(8)) dut (
        .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .frame_tick(frame_tick),
        .frame_widths(frame_widths), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en), .wall_hit(wall_hit),
        .busy(busy), .overrun(overrun)
    );

    always #5 vid_clk = ~vid_clk;

    typedef struct packed {
        logic [N-1:0][11:0] x;
        logic [N-1:0][11:0] y;
        logic [N-1:0]       en;
        logic [N-1:0][3:0]  hit;
    } exp_t;

    typedef struct {
        bit en;
        int x, y, vx, vy;
    } wr_t;

    int sx [N] = '{16, 32, 8, 24};
    int sy [N] = '{16, 8, 32, 24};

    int   m_x [N], m_y [N], m_vx [N], m_vy [N];
    bit   m_en [N];
    int   fw [4];
    exp_t q [$];
    int   n_checks = 0, n_errors = 0;
    int   ovr_seen = 0, ovr_exp = 0;
    bit   mon_en = 1'b0;
    logic busy_prev = 1'b0;
    exp_t last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int abs_sat(input int v);
        return (v == -128) ? 127 : ((v < 0) ? -v : v);
    endfunction

    function automatic void axis(inout int p, inout int v, input int lo, input int hi,
                                 output bit hl, output bit hh);
        int nx;
        nx = p + v;
        hl = 1'b0;
        hh = 1'b0;
        if (hi < lo) p = lo;
        else if (nx < lo) begin p = lo; v = abs_sat(v); hl = 1'b1; end
        else if (nx > hi) begin p = hi; v = -abs_sat(v); hh = 1'b1; end
        else p = nx;
    endfunction

    function automatic bit [3:0] model_obj(input int i);
        bit a, b, c, d;
        if (!m_en[i]) return 4'b0000;
        axis(m_x[i], m_vx[i], fw[0], 1280 - fw[1] - sx[i], a, b);
        axis(m_y[i], m_vy[i], fw[2], 720 - fw[3] - sy[i], c, d);
        return {d, c, b, a};
    endfunction

    function automatic void model_set(input int i, input wr_t w);
        m_en[i] = w.en; m_x[i] = w.x; m_y[i] = w.y; m_vx[i] = w.vx; m_vy[i] = w.vy;
    endfunction

    // Expected committed frame; an optional write to object wj lands during slot wk
    function automatic void predict(input bit do_w, input int wk, input int wj, input wr_t w);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            bit [3:0] h;
            if (do_w && i == wj) begin
                if (wj < wk) begin h = model_obj(i); model_set(i, w); end
                else if (wj == wk) begin model_set(i, w); h = 4'b0000; end
                else begin model_set(i, w); h = model_obj(i); end
            end else begin
                h = model_obj(i);
            end
            e.hit[i] = h;
        end
        for (int i = 0; i < N; i++) begin
            e.x[i]  = 12'(m_x[i]);
            e.y[i]  = 12'(m_y[i]);
            e.en[i] = m_en[i];
        end
        q.push_back(e);
    endfunction

    task automatic drive_cfg(input int idx, input wr_t w);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_en  = w.en;
        cfg_x   = 12'(w.x);
        cfg_y   = 12'(w.y);
        cfg_vx  = 8'(w.vx);
        cfg_vy  = 8'(w.vy);
    endtask

    task automatic cfg_write(input int idx, input wr_t w);
        drive_cfg(idx, w);
        model_set(idx, w);
        @(posedge vid_clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_widths(input int l, input int r, input int t, input int b);
        fw[0] = l; fw[1] = r; fw[2] = t; fw[3] = b;
        for (int i = 0; i < 4; i++) frame_widths[i] = 8'(fw[i]);
    endtask

    task automatic run_frame(input bit do_w, input int wk, input int wj, input wr_t w, input bit ovr);
        int cnt;
        predict(do_w, wk, wj, w);
        if (ovr) ovr_exp++;
        frame_tick = 1'b1;
        @(posedge vid_clk); #1;
        chk("busy_rise", 128'(busy), 128'(1));
        cnt = 1;
        while (busy && cnt < 40) begin
            frame_tick = ovr && (cnt == 1);
            if (do_w && cnt == wk + 1) drive_cfg(wj, w);
            else cfg_we = 1'b0;
            @(posedge vid_clk); #1;
            cnt++;
        end
        frame_tick = 1'b0;
        cfg_we     = 1'b0;
        chk("latency", 128'(cnt), 128'(N + 2));
    endtask

    // Monitor: compares each commit against the scoreboard, and holds outputs stable otherwise
    always @(negedge vid_clk) begin
        exp_t cur, e;
        cur = {obj_x, obj_y, obj_en, wall_hit};
        if (mon_en) begin
            if (busy_prev && !busy) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL commit: got %h with no expected frame queued", cur);
                end else begin
                    e = q.pop_front();
                    chk("commit", 128'(cur), 128'(e));
                end
            end else begin
                chk("stable", 128'(cur), 128'(last));
            end
            if (overrun) ovr_seen++;
            last = cur;
        end
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        wr_t w, z;
        z = '{en: 1'b0, x: 0, y: 0, vx: 0, vy: 0};
        vid_reset_n = 1'b0;
        frame_tick  = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_x       = '0;
        cfg_y       = '0;
        cfg_vx      = '0;
        cfg_vy      = '0;
        for (int i = 0; i < N; i++) model_set(i, z);
        set_widths(8, 8, 8, 8);
        repeat (3) @(posedge vid_clk);
        #1;
        chk("rst_x", 128'(obj_x), 128'(0));
        chk("rst_en_busy", 128'({obj_en, busy, overrun, wall_hit}), 128'(0));
        vid_reset_n = 1'b1;
        last   = '0;
        mon_en = 1'b1;
        @(posedge vid_clk); #1;

        w = '{en: 1'b1, x: 100, y: 50, vx: 3, vy: -2};
        cfg_write(0, w);
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("free_x", 128'(obj_x[0]), 128'(103));
        chk("free_y", 128'(obj_y[0]), 128'(48));
        chk("free_hit", 128'(wall_hit), 128'(0));

        w = '{en: 1'b1, x: 1254, y: 300, vx: 5, vy: 0};
        cfg_write(0, w);
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("right_x", 128'(obj_x[0]), 128'(1256));
        chk("right_hit", 128'(wall_hit[0]), 128'(4'b0010));
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("right_x2", 128'(obj_x[0]), 128'(1251));

        w = '{en: 1'b1, x: 200, y: 10, vx: 0, vy: -128};
        cfg_write(0, w);
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("top_y", 128'(obj_y[0]), 128'(8));
        chk("top_hit", 128'(wall_hit[0][2]), 128'(1));
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("top_y2", 128'(obj_y[0]), 128'(135));

        w = '{en: 1'b1, x: 100, y: 50, vx: 3, vy: 0};
        cfg_write(0, w);
        w.x = 500;
        run_frame(1'b1, 0, 0, w, 1'b0);
        chk("cfg_prio_x", 128'(obj_x[0]), 128'(500));

        run_frame(1'b0, 0, 0, z, 1'b1);
        chk("overrun", 128'(ovr_seen), 128'(ovr_exp));

        w = '{en: 1'b0, x: 300, y: 300, vx: 5, vy: 5};
        cfg_write(1, w);
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("dis_x", 128'(obj_x[1]), 128'(300));
        chk("dis_en", 128'(obj_en[1]), 128'(0));

        for (int f = 0; f < 60; f++) begin
            bit dw, ov;
            int wk, wj, nw;
            set_widths(int'($urandom_range(255)), int'($urandom_range(255)),
                       int'($urandom_range(255)), int'($urandom_range(255)));
            nw = int'($urandom_range(3));
            for (int k = 0; k < nw; k++) begin
                w.en = ($urandom_range(3) != 0);
                w.x  = int'($urandom_range(1400));
                w.y  = int'($urandom_range(800));
                w.vx = int'($urandom_range(255)) - 128;
                w.vy = int'($urandom_range(255)) - 128;
                cfg_write(int'($urandom_range(N - 1)), w);
            end
            dw   = ($urandom_range(9) < 3);
            ov   = ($urandom_range(9) == 0);
            wk   = int'($urandom_range(N - 1));
            wj   = int'($urandom_range(N - 1));
            w.en = 1'b1;
            w.x  = int'($urandom_range(1400));
            w.y  = int'($urandom_range(800));
            w.vx = int'($urandom_range(255)) - 128;
            w.vy = int'($urandom_range(255)) - 128;
            run_frame(dw, wk, wj, w, ov);
        end
        chk("overrun_total", 128'(ovr_seen), 128'(ovr_exp));

        frame_tick = 1'b1;
        @(posedge vid_clk); #1;
        frame_tick = 1'b0;
        @(posedge vid_clk); #1;
        mon_en = 1'b0;
        vid_reset_n = 1'b0;
        #1;
        chk("midrst_xy", 128'({obj_x, obj_y}), 128'(0));
        chk("midrst_en_busy", 128'({obj_en, busy}), 128'(0));
        @(posedge vid_clk); #1;
        vid_reset_n = 1'b1;
        for (int i = 0; i < N; i++) model_set(i, z);
        set_widths(8, 8, 8, 8);
        last   = '0;
        mon_en = 1'b1;
        @(posedge vid_clk); #1;
        w = '{en: 1'b1, x: 600, y: 400, vx: -7, vy: 9};
        cfg_write(2, w);
        run_frame(1'b0, 0, 0, z, 1'b0);
        chk("post_rst_x", 128'(obj_x[2]), 128'(593));

        repeat (2) @(posedge vid_clk);
        #1;
        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
